// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave and its synchronizers.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = 3;

    localparam logic [SPI_DATA_W-1:0] SPI_TX_UNDERRUN_BYTE = 8'h00;
    localparam logic [SPI_CNT_W-1:0]  SPI_LAST_BIT         = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    function automatic logic [SPI_DATA_W-1:0] spi_tx_next(
        input logic                  hold_empty,
        input logic [SPI_DATA_W-1:0] hold
    );
        return hold_empty ? SPI_TX_UNDERRUN_BYTE : hold;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input plus registered
// single-cycle rise/fall event detection.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign lvl = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled in the clk domain. Optional macro
// SPI_SLAVE_RX_OVERRUN_EN discards unaccepted bytes and flags rx_overrun.
//
// state    | meaning
// ST_IDLE  | ss high, miso tri-stated (miso_oe 0), waiting for ss_fall
// ST_SHIFT | frame active, shifting bytes on sck edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  busy
);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .async_in(sck),
        .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .async_in(ss),
        .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(mosi),
        .lvl(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sck_lvl, ss_lvl, mosi_rise, mosi_fall};

    spi_state_t            state;
    logic [SPI_DATA_W-1:0] tx_hold;
    logic [SPI_DATA_W-1:0] tx_shift;
    logic [SPI_DATA_W-1:0] rx_shift;
    logic [SPI_CNT_W-1:0]  bit_cnt;
    logic [SPI_DATA_W-1:0] tx_next;
    logic [SPI_DATA_W-1:0] rx_byte;
    logic                  rx_accept;

    assign tx_next   = spi_tx_next(tx_ready, tx_hold);
    assign rx_byte   = {rx_shift[SPI_DATA_W-2:0], mosi_s};
    assign rx_accept = rx_valid && rx_ready;

`ifndef SPI_SLAVE_RX_OVERRUN_EN
    assign rx_overrun = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_hold  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            rx_overrun <= 1'b0;
`endif
        end else begin
            if (tx_valid && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end
            if (rx_accept) begin
                rx_valid <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
                rx_overrun <= 1'b0;
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state    <= ST_SHIFT;
                        busy     <= 1'b1;
                        miso_oe  <= 1'b1;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= tx_next;
                        miso     <= tx_next[SPI_DATA_W-1];
                        tx_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        miso_oe  <= 1'b0;
                        miso     <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_byte;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == SPI_LAST_BIT) begin
                            if (!rx_valid || rx_accept) begin
                                rx_data  <= rx_byte;
                                rx_valid <= 1'b1;
                            end else begin
`ifdef SPI_SLAVE_RX_OVERRUN_EN
                                rx_overrun <= 1'b1;
`else
                                rx_data <= rx_byte;
`endif
                            end
                            tx_shift <= tx_next;
                            miso     <= tx_next[SPI_DATA_W-1];
                            tx_ready <= 1'b1;
                        end
                    end else if (sck_fall && bit_cnt != '0) begin
                        // the fall closing a byte is skipped so the next MSB stays on miso
                        tx_shift <= {tx_shift[SPI_DATA_W-2:0], 1'b0};
                        miso     <= tx_shift[SPI_DATA_W-2];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as a mode-0 SPI master.
module tb_spi_slave;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       busy;

    int applied = 0;
    int miscompares = 0;

    spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        bit         load;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 100) begin
            wait_clk(1);
            n++;
        end
        check("tx_ready_wait", {7'd0, tx_ready}, 8'h01);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("tx_ready_after_load", {7'd0, tx_ready}, 8'h00);
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("rx_valid_after_accept", {7'd0, rx_valid}, 8'h00);
    endtask

    // Shifts n bits MSB first; optionally pulses rx_ready so it lands on the
    // clk cycle in which the DUT completes the byte.
    task automatic send_bits(input logic [7:0] b, input int n, input bit acc_on_last,
                             output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_clk(HALF);
            sck = 1'b1;
            got = {got[6:0], miso};
            if (acc_on_last && i == n - 1) begin
                wait_clk(SYNC_STAGES + 1);
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
                wait_clk(HALF - SYNC_STAGES - 2);
            end else begin
                wait_clk(HALF);
            end
            sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        logic [7:0] got;

        vecs[0] = '{tx: 8'hA5, load: 1'b1, mosi_b: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'hFF, load: 1'b1, mosi_b: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
        vecs[2] = '{tx: 8'h00, load: 1'b1, mosi_b: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
        vecs[3] = '{tx: 8'h5A, load: 1'b1, mosi_b: 8'hC3, exp_miso: 8'h5A, exp_rx: 8'hC3};
        vecs[4] = '{tx: 8'h99, load: 1'b0, mosi_b: 8'h7E, exp_miso: 8'h00, exp_rx: 8'h7E};

        wait_clk(3);
        check("reset_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_miso", {7'd0, miso}, 8'h00);
        rst = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].load) load_tx(vecs[v].tx);
            ss_low();
            check("vec_busy", {7'd0, busy}, 8'h01);
            check("vec_miso_oe", {7'd0, miso_oe}, 8'h01);
            send_bits(vecs[v].mosi_b, 8, 1'b0, got);
            ss_high();
            check("vec_rx_data", rx_data, vecs[v].exp_rx);
            check("vec_rx_valid", {7'd0, rx_valid}, 8'h01);
            check("vec_miso_byte", got, vecs[v].exp_miso);
            check("vec_miso_oe_idle", {7'd0, miso_oe}, 8'h00);
            check("vec_miso_idle", {7'd0, miso}, 8'h00);
            accept_rx();
        end

        // two bytes in one frame, second byte is a tx underrun
        load_tx(8'h96);
        ss_low();
        send_bits(8'h11, 8, 1'b0, got);
        check("two_rx_first", rx_data, 8'h11);
        check("two_miso_first", got, 8'h96);
        accept_rx();
        send_bits(8'h22, 8, 1'b0, got);
        ss_high();
        check("two_rx_second", rx_data, 8'h22);
        check("two_rx_valid", {7'd0, rx_valid}, 8'h01);
        check("two_miso_underrun", got, 8'h00);
        accept_rx();

        // partial byte aborted by ss, then a full frame
        ss_low();
        send_bits(8'hB0, 5, 1'b0, got);
        ss_high();
        check("partial_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("partial_rx_data", rx_data, 8'h22);
        check("partial_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("partial_busy", {7'd0, busy}, 8'h00);
        ss_low();
        send_bits(8'h81, 8, 1'b0, got);
        ss_high();
        check("after_partial_rx", rx_data, 8'h81);
        check("after_partial_valid", {7'd0, rx_valid}, 8'h01);
        accept_rx();

        // overrun: two bytes with rx_ready held low
        ss_low();
        send_bits(8'h55, 8, 1'b0, got);
        send_bits(8'hAA, 8, 1'b0, got);
        ss_high();
        check("ovr_rx_valid", {7'd0, rx_valid}, 8'h01);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        check("ovr_rx_data", rx_data, 8'h55);
        check("ovr_flag", {7'd0, rx_overrun}, 8'h01);
`else
        check("ovr_rx_data", rx_data, 8'hAA);
        check("ovr_flag", {7'd0, rx_overrun}, 8'h00);
`endif

        // byte completes in the same cycle the pending byte is accepted
        ss_low();
        send_bits(8'h3C, 8, 1'b1, got);
        ss_high();
        check("coinc_rx_data", rx_data, 8'h3C);
        check("coinc_rx_valid", {7'd0, rx_valid}, 8'h01);
        check("coinc_overrun", {7'd0, rx_overrun}, 8'h00);

        // reset mid-frame with a pending rx byte and a full tx holding register
        ss_low();
        load_tx(8'h77);
        send_bits(8'hE7, 4, 1'b0, got);
        rst = 1'b1;
        ss  = 1'b1;
        #1;
        check("rst_miso", {7'd0, miso}, 8'h00);
        check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_rx_overrun", {7'd0, rx_overrun}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        check("post_rst_busy", {7'd0, busy}, 8'h00);
        load_tx(8'h0F);
        ss_low();
        send_bits(8'hF0, 8, 1'b0, got);
        ss_high();
        check("post_rst_rx", rx_data, 8'hF0);
        check("post_rst_valid", {7'd0, rx_valid}, 8'h01);
        check("post_rst_miso", got, 8'h0F);
        accept_rx();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
